// File: rtl/mips_if.sv
// rtl/mips_if.sv - instruction/data memory bus between the mips core and its memories
interface mips_if;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output pc, memwrite, aluout, writedata, input instr, readdata);
    modport slave  (input pc, memwrite, aluout, writedata, output instr, readdata);
endinterface

// File: rtl/mips.sv
// rtl/mips.sv - 5-stage pipelined MIPS subset core with forwarding, stalls and D-stage branches
module mips (
    input  logic   clk,
    input  logic   reset,
    mips_if.master bus
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    typedef struct packed {
        logic        regwrite, memtoreg, memwrite, alusrc;
        alu_op_e     aluctrl;
        logic [4:0]  rs, rt, dst;
        logic [31:0] rd1, rd2, imm;
    } de_t;
    typedef struct packed {
        logic        regwrite, memtoreg, memwrite;
        logic [4:0]  dst;
        logic [31:0] alu, wd;
    } em_t;
    typedef struct packed {
        logic        regwrite, memtoreg;
        logic [4:0]  dst;
        logic [31:0] alu, rdata;
    } mw_t;

    logic [31:0] pc_q, pc_d, fd_instr_q, fd_instr_d, fd_pc4_q, fd_pc4_d;
    de_t         de_q, de_d;
    em_t         em_q, em_d;
    mw_t         mw_q, mw_d;
    logic [31:0] rf_q [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, rd1, rd2, cmp_a, cmp_b, w_result, fwd_a, fwd_b, src_b, alu_y;
    logic        c_regwrite, c_memtoreg, c_memwrite, c_alusrc, c_regdst, c_branch, c_jump;
    alu_op_e     c_aluctrl;
    logic        w_we, lu_stall, br_stall, stall, redirect;
    logic [31:0] redirect_pc;

    assign op    = fd_instr_q[31:26];
    assign rs    = fd_instr_q[25:21];
    assign rt    = fd_instr_q[20:16];
    assign rd    = fd_instr_q[15:11];
    assign funct = fd_instr_q[5:0];
    assign simm  = {{16{fd_instr_q[15]}}, fd_instr_q[15:0]};

    always_comb begin
        c_regwrite = 1'b0;
        c_memtoreg = 1'b0;
        c_memwrite = 1'b0;
        c_alusrc   = 1'b0;
        c_regdst   = 1'b0;
        c_branch   = 1'b0;
        c_jump     = 1'b0;
        c_aluctrl  = ALU_ADD;
        case (op)
            6'b000000: begin
                c_regdst = 1'b1;
                case (funct)
                    6'b100000: begin c_regwrite = 1'b1; c_aluctrl = ALU_ADD; end
                    6'b100010: begin c_regwrite = 1'b1; c_aluctrl = ALU_SUB; end
                    6'b100100: begin c_regwrite = 1'b1; c_aluctrl = ALU_AND; end
                    6'b100101: begin c_regwrite = 1'b1; c_aluctrl = ALU_OR;  end
                    6'b101010: begin c_regwrite = 1'b1; c_aluctrl = ALU_SLT; end
                    default: ;
                endcase
            end
            6'b100011: begin c_regwrite = 1'b1; c_memtoreg = 1'b1; c_alusrc = 1'b1; end
            6'b101011: begin c_memwrite = 1'b1; c_alusrc = 1'b1; end
            6'b000100: c_branch = 1'b1;
            6'b001000: begin c_regwrite = 1'b1; c_alusrc = 1'b1; end
            6'b000010: c_jump = 1'b1;
            default: ;
        endcase
    end

    // Register reads see the W-stage write of this same cycle.
    assign w_result = mw_q.memtoreg ? mw_q.rdata : mw_q.alu;
    assign w_we     = mw_q.regwrite && (mw_q.dst != 5'd0);
    assign rd1 = (rs == 5'd0) ? 32'd0 : (w_we && mw_q.dst == rs) ? w_result : rf_q[rs];
    assign rd2 = (rt == 5'd0) ? 32'd0 : (w_we && mw_q.dst == rt) ? w_result : rf_q[rt];

    assign cmp_a = (rs != 5'd0 && em_q.regwrite && em_q.dst == rs) ? em_q.alu : rd1;
    assign cmp_b = (rt != 5'd0 && em_q.regwrite && em_q.dst == rt) ? em_q.alu : rd2;

    assign lu_stall = de_q.memtoreg && (de_q.dst != 5'd0) && (de_q.dst == rs || de_q.dst == rt);
    assign br_stall = c_branch &&
        ((de_q.regwrite && de_q.dst != 5'd0 && (de_q.dst == rs || de_q.dst == rt)) ||
         (em_q.memtoreg && em_q.dst != 5'd0 && (em_q.dst == rs || em_q.dst == rt)));
    assign stall    = lu_stall || br_stall;

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = fd_pc4_q + {simm[29:0], 2'b00};
        if (c_jump) begin
            redirect    = !stall;
            redirect_pc = {fd_pc4_q[31:28], fd_instr_q[25:0], 2'b00};
        end else if (c_branch && cmp_a == cmp_b) begin
            redirect    = !stall;
        end
    end

    always_comb begin
        pc_d       = pc_q + 32'd4;
        fd_instr_d = bus.instr;
        fd_pc4_d   = pc_q + 32'd4;
        de_d       = '0;
        if (stall) begin
            pc_d       = pc_q;
            fd_instr_d = fd_instr_q;
            fd_pc4_d   = fd_pc4_q;
        end else begin
            de_d.regwrite = c_regwrite;
            de_d.memtoreg = c_memtoreg;
            de_d.memwrite = c_memwrite;
            de_d.alusrc   = c_alusrc;
            de_d.aluctrl  = c_aluctrl;
            de_d.rs       = rs;
            de_d.rt       = rt;
            de_d.dst      = c_regdst ? rd : rt;
            de_d.rd1      = rd1;
            de_d.rd2      = rd2;
            de_d.imm      = simm;
            if (redirect) begin
                pc_d       = redirect_pc;
                fd_instr_d = 32'd0;
                fd_pc4_d   = 32'd0;
            end
        end
    end

    // M-stage result wins over W; a lw in M never reaches here thanks to the load-use stall.
    always_comb begin
        fwd_a = de_q.rd1;
        fwd_b = de_q.rd2;
        if (de_q.rs != 5'd0 && em_q.regwrite && em_q.dst == de_q.rs) fwd_a = em_q.alu;
        else if (de_q.rs != 5'd0 && w_we && mw_q.dst == de_q.rs)     fwd_a = w_result;
        if (de_q.rt != 5'd0 && em_q.regwrite && em_q.dst == de_q.rt) fwd_b = em_q.alu;
        else if (de_q.rt != 5'd0 && w_we && mw_q.dst == de_q.rt)     fwd_b = w_result;
        src_b = de_q.alusrc ? de_q.imm : fwd_b;
        case (de_q.aluctrl)
            ALU_SUB: alu_y = fwd_a - src_b;
            ALU_AND: alu_y = fwd_a & src_b;
            ALU_OR:  alu_y = fwd_a | src_b;
            ALU_SLT: alu_y = {31'd0, $signed(fwd_a) < $signed(src_b)};
            default: alu_y = fwd_a + src_b;
        endcase
        em_d          = '0;
        em_d.regwrite = de_q.regwrite;
        em_d.memtoreg = de_q.memtoreg;
        em_d.memwrite = de_q.memwrite;
        em_d.dst      = de_q.dst;
        em_d.alu      = alu_y;
        em_d.wd       = fwd_b;
        mw_d          = '0;
        mw_d.regwrite = em_q.regwrite;
        mw_d.memtoreg = em_q.memtoreg;
        mw_d.dst      = em_q.dst;
        mw_d.alu      = em_q.alu;
        mw_d.rdata    = bus.readdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= 32'd0;
            fd_instr_q <= 32'd0;
            fd_pc4_q   <= 32'd0;
            de_q       <= '0;
            em_q       <= '0;
            mw_q       <= '0;
        end else begin
            pc_q       <= pc_d;
            fd_instr_q <= fd_instr_d;
            fd_pc4_q   <= fd_pc4_d;
            de_q       <= de_d;
            em_q       <= em_d;
            mw_q       <= mw_d;
        end
    end

    // The register file keeps its contents through reset; only in-flight writes are dropped.
    always_ff @(posedge clk) begin
        if (reset && w_we) rf_q[mw_q.dst] <= w_result;
    end

    assign bus.pc        = pc_q;
    assign bus.memwrite  = em_q.memwrite;
    assign bus.aluout    = em_q.alu;
    assign bus.writedata = em_q.wd;
endmodule

// File: tb/tb_mips.sv
// tb/tb_mips.sv - directed program tests for the mips pipeline core
module tb_mips;
    logic clk = 1'b0;
    logic reset = 1'b0;
    mips_if bus ();
    mips dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    assign bus.instr    = imem[bus.pc[7:2]];
    assign bus.readdata = dmem[bus.aluout[7:2]];
    always @(posedge clk) if (bus.memwrite) dmem[bus.aluout[7:2]] <= bus.writedata;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] pc_tr [$];
    logic [31:0] st_a [$];
    logic [31:0] st_d [$];

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        reset = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        pc_tr.delete();
        st_a.delete();
        st_d.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            pc_tr.push_back(bus.pc);
            if (bus.memwrite) begin
                st_a.push_back(bus.aluout);
                st_d.push_back(bus.writedata);
            end
        end
    endtask

    task automatic load_fwd_lu();
        imem[0] = enc_i(6'b001000, 5'd0, 5'd2, 16'd5);
        imem[1] = enc_i(6'b001000, 5'd2, 5'd3, 16'd7);
        imem[2] = enc_i(6'b101011, 5'd0, 5'd3, 16'd84);
        imem[3] = enc_i(6'b100011, 5'd0, 5'd4, 16'd84);
        imem[4] = enc_r(5'd4, 5'd4, 5'd5, 6'b100000);
        imem[5] = enc_i(6'b101011, 5'd0, 5'd5, 16'd88);
    endtask

    initial begin
        // Reset behaviour and sequential fetch
        start();
        @(posedge clk);
        @(negedge clk);
        check("rst_pc", bus.pc, 32'd0);
        check("rst_memwrite", {31'd0, bus.memwrite}, 32'd0);
        check("rst_aluout", bus.aluout, 32'd0);
        check("rst_writedata", bus.writedata, 32'd0);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rel_pc1", bus.pc, 32'd4);
        @(posedge clk); @(negedge clk);
        check("rel_pc2", bus.pc, 32'd8);

        // Forwarding followed by load-use stall
        start();
        load_fwd_lu();
        release_reset();
        run(16);
        check("fwd_pc_e1", pc_tr[0], 32'd4);
        check("fwd_pc_e2", pc_tr[1], 32'd8);
        check("fwd_pc_e3", pc_tr[2], 32'd12);
        check("fwd_pc_e4", pc_tr[3], 32'd16);
        check("lu_pc_e5", pc_tr[4], 32'd20);
        check("lu_pc_hold", pc_tr[5], 32'd20);
        check("lu_pc_e7", pc_tr[6], 32'd24);
        check("fwd_store_cnt", st_a.size(), 32'd2);
        check("fwd_store_addr", st_a[0], 32'd84);
        check("fwd_store_data", st_d[0], 32'd12);
        check("lu_store_addr", st_a[1], 32'd88);
        check("lu_store_data", st_d[1], 32'd24);

        // Reset mid-program drops the store that was in flight
        start();
        load_fwd_lu();
        release_reset();
        run(3);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check("midrst_mw1", {31'd0, bus.memwrite}, 32'd0);
        @(posedge clk); @(negedge clk);
        check("midrst_mw2", {31'd0, bus.memwrite}, 32'd0);
        check("midrst_pc", bus.pc, 32'd0);

        // Register file survives reset ($5 = 24 from the load-use program)
        start();
        imem[0] = enc_i(6'b101011, 5'd0, 5'd5, 16'd96);
        release_reset();
        run(6);
        check("rf_keep_cnt", st_a.size(), 32'd1);
        check("rf_keep_addr", st_a[0], 32'd96);
        check("rf_keep_data", st_d[0], 32'd24);

        // Taken branch with one branch stall
        start();
        imem[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd1);
        imem[1] = enc_i(6'b000100, 5'd1, 5'd1, 16'd1);
        imem[2] = enc_i(6'b101011, 5'd0, 5'd1, 16'd0);
        imem[3] = enc_i(6'b101011, 5'd0, 5'd1, 16'd4);
        release_reset();
        run(10);
        check("br_pc_e2", pc_tr[1], 32'd8);
        check("br_pc_stall", pc_tr[2], 32'd8);
        check("br_pc_target", pc_tr[3], 32'd12);
        check("br_store_cnt", st_a.size(), 32'd1);
        check("br_store_addr", st_a[0], 32'd4);
        check("br_store_data", st_d[0], 32'd1);

        // Jump squashes the slot instruction
        start();
        imem[0] = {6'b000010, 26'h4};
        imem[1] = enc_i(6'b101011, 5'd0, 5'd0, 16'd0);
        imem[4] = enc_i(6'b101011, 5'd0, 5'd0, 16'd8);
        release_reset();
        run(8);
        check("j_pc_e1", pc_tr[0], 32'd4);
        check("j_pc_e2", pc_tr[1], 32'h10);
        check("j_pc_e3", pc_tr[2], 32'h14);
        check("j_store_cnt", st_a.size(), 32'd1);
        check("j_store_addr", st_a[0], 32'd8);

        // Signed set-less-than
        start();
        imem[0] = enc_i(6'b001000, 5'd0, 5'd6, 16'hFFFF);
        imem[1] = enc_r(5'd6, 5'd0, 5'd7, 6'b101010);
        imem[2] = enc_i(6'b101011, 5'd0, 5'd7, 16'd0);
        release_reset();
        run(8);
        check("slt_store_cnt", st_a.size(), 32'd1);
        check("slt_store_data", st_d[0], 32'd1);

        // sub/and/or, and an unsupported funct behaving as a NOP
        start();
        imem[0] = enc_i(6'b001000, 5'd0, 5'd8, 16'd12);
        imem[1] = enc_i(6'b001000, 5'd0, 5'd9, 16'd10);
        imem[2] = enc_r(5'd8, 5'd9, 5'd10, 6'b100010);
        imem[3] = enc_r(5'd8, 5'd9, 5'd10, 6'b100110);
        imem[4] = enc_r(5'd8, 5'd9, 5'd11, 6'b100100);
        imem[5] = enc_r(5'd8, 5'd9, 5'd12, 6'b100101);
        imem[6] = enc_i(6'b101011, 5'd0, 5'd10, 16'd0);
        imem[7] = enc_i(6'b101011, 5'd0, 5'd11, 16'd4);
        imem[8] = enc_i(6'b101011, 5'd0, 5'd12, 16'd8);
        release_reset();
        run(14);
        check("alu_store_cnt", st_a.size(), 32'd3);
        check("sub_nop_data", st_d[0], 32'd2);
        check("and_data", st_d[1], 32'd8);
        check("or_data", st_d[2], 32'd14);
        check("or_addr", st_a[2], 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
